// File: rtl/rect_filler.sv
// Clipped-rectangle fill: one DDR2 address + two 128-bit beats per 8-pixel burst, byte-masked edges.
// Done at accept+2+2*bursts; af_full/wdf_full stall the current beat in place, strobes are combinational.
module rect_filler #(
    parameter int H_RES = 800,
    parameter int V_RES = 600
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    output logic         ready,
    input  logic [9:0]   x0,
    input  logic [9:0]   y0,
    input  logic [9:0]   x1,
    input  logic [9:0]   y1,
    input  logic [23:0]  color,
    input  logic [31:0]  frame_base,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic         wdf_wr_en,
    output logic [15:0]  wdf_mask_din,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, SETUP, BEAT0, BEAT1, FIN} state_t;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

    state_t      state;
    logic [9:0]  x0_q, y0_q, x1_q, y1_q, y_q;
    logic [6:0]  bx_q;
    logic [23:0] color_q;
    logic [5:0]  base_q;

    logic [9:0]  x1_c, y1_c;
    logic        beat0_go, beat1_go, row_end;
    logic [9:0]  pix;
    logic [15:0] mask_c;

    logic unused_base;
    assign unused_base = ^{frame_base[31:28], frame_base[21:0]};

    assign x1_c     = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign y1_c     = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    assign beat0_go = (state == BEAT0) && !af_full && !wdf_full;
    assign beat1_go = (state == BEAT1) && !wdf_full;
    assign row_end  = (bx_q == x1_q[9:3]);

    assign ready        = (state == IDLE);
    assign done         = (state == FIN);
    assign af_wr_en     = beat0_go;
    assign wdf_wr_en    = beat0_go || beat1_go;
    assign af_addr_din  = {6'b0, base_q, y_q, bx_q, 2'b00};
    assign wdf_din      = {4{8'h00, color_q}};
    assign wdf_mask_din = mask_c;

    // Pixel index of lane k is {bx, beat, k}; lanes outside [x0, x1q] are masked off.
    always_comb begin
        mask_c = 16'hFFFF;
        pix    = '0;
        if (state == BEAT0 || state == BEAT1) begin
            for (int k = 0; k < 4; k++) begin
                pix = {bx_q, state == BEAT1, k[1:0]};
                mask_c[4*k +: 4] = {4{(pix < x0_q) || (pix > x1_q)}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            y_q     <= '0;
            bx_q    <= '0;
            color_q <= '0;
            base_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        color_q <= color;
                        base_q  <= frame_base[27:22];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    x1_q <= x1_c;
                    y1_q <= y1_c;
                    if (x0_q > x1_c || y0_q > y1_c) begin
                        state <= FIN;
                    end else begin
                        y_q   <= y0_q;
                        bx_q  <= x0_q[9:3];
                        state <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (beat0_go) state <= BEAT1;
                end
                BEAT1: begin
                    if (beat1_go) begin
                        if (row_end && y_q == y1_q) begin
                            state <= FIN;
                        end else if (row_end) begin
                            bx_q  <= x0_q[9:3];
                            y_q   <= y_q + 10'd1;
                            state <= BEAT0;
                        end else begin
                            bx_q  <= bx_q + 7'd1;
                            state <= BEAT0;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_filler.sv
// Randomised and directed bench for rect_filler against a queue-based model of the expected write stream.
module tb_rect_filler;
    localparam int H = 800;
    localparam int V = 600;

    logic         clk, rst_n, valid, ready;
    logic [9:0]   x0_s, y0_s, x1_s, y1_s;
    logic [23:0]  col_s;
    logic [31:0]  base_s;
    logic         af_full, wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en, wdf_wr_en, done;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    rect_filler #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready),
        .x0(x0_s), .y0(y0_s), .x1(x1_s), .y1(y1_s),
        .color(col_s), .frame_base(base_s),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_wr_en(wdf_wr_en),
        .wdf_mask_din(wdf_mask_din), .done(done)
    );

    typedef struct packed {
        logic         af;
        logic [30:0]  addr;
        logic [15:0]  mask;
        logic [127:0] din;
    } item_t;

    item_t exp_q[$];
    item_t log_q[$];
    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int nb      = 0;
    int bp_mode = 0;
    bit stall_done = 0;
    bit beat1_seen = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected write stream: rows y0..y1c, bursts x0/8..x1c/8, two beats each.
    task automatic build(input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] col, input logic [31:0] base);
        int x1c, y1c, p;
        item_t it;
        x1c = (x1 > H - 1) ? H - 1 : x1;
        y1c = (y1 > V - 1) ? V - 1 : y1;
        nb = 0;
        if (x0 <= x1c && y0 <= y1c) begin
            for (int y = y0; y <= y1c; y++) begin
                for (int bx = x0 / 8; bx <= x1c / 8; bx++) begin
                    nb++;
                    for (int beat = 0; beat < 2; beat++) begin
                        it.af   = (beat == 0);
                        it.addr = {6'b0, base[27:22], 10'(y), 7'(bx), 2'b00};
                        it.din  = {4{8'h00, col}};
                        it.mask = 16'h0000;
                        for (int k = 0; k < 4; k++) begin
                            p = bx * 8 + beat * 4 + k;
                            if (p < x0 || p > x1c) it.mask[4*k +: 4] = 4'hF;
                        end
                        exp_q.push_back(it);
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (rst_n) begin
            beat1_seen = wdf_wr_en && !af_wr_en;
            vectors++;
            if ((af_wr_en && (af_full || wdf_full || !wdf_wr_en)) || (wdf_wr_en && wdf_full)) begin
                errors++;
                $display("FAIL handshake: af_wr_en=%0b wdf_wr_en=%0b af_full=%0b wdf_full=%0b",
                         af_wr_en, wdf_wr_en, af_full, wdf_full);
            end
            if (wdf_wr_en) begin
                item_t a, e;
                a.af = af_wr_en; a.addr = af_addr_din; a.mask = wdf_mask_din; a.din = wdf_din;
                log_q.push_back(a);
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: addr=%0h mask=%0h", a.addr, a.mask);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e) begin
                        errors++;
                        $display("FAIL write: got af=%0b addr=%0h mask=%0h din=%0h expected af=%0b addr=%0h mask=%0h din=%0h",
                                 a.af, a.addr, a.mask, a.din, e.af, e.addr, e.mask, e.din);
                    end
                end
            end
            if (bp_mode == 2 && af_full) begin
                vectors++;
                if (af_wr_en || wdf_wr_en || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_strobe: af_wr_en=%0b wdf_wr_en=%0b", af_wr_en, wdf_wr_en);
                end else if (af_addr_din != exp_q[0].addr) begin
                    errors++;
                    $display("FAIL stall_addr: got %0h expected %0h", af_addr_din, exp_q[0].addr);
                end
            end
        end
    end

    // Backpressure: 0 none, 1 random, 2 one 3-cycle af_full stall in BEAT0, 3 wdf_full toggling.
    initial begin
        int stall_left;
        stall_left = 0;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1: begin
                    af_full  = ($urandom_range(0, 3) == 0);
                    wdf_full = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    wdf_full = 0;
                    if (stall_left > 0) begin
                        af_full = 1;
                        stall_left--;
                    end else if (beat1_seen && !stall_done) begin
                        af_full = 1;
                        stall_left = 2;
                        stall_done = 1;
                    end else begin
                        af_full = 0;
                    end
                end
                3: begin
                    af_full  = 0;
                    wdf_full = ~wdf_full;
                end
                default: begin
                    af_full  = 0;
                    wdf_full = 0;
                end
            endcase
        end
    end

    task automatic run(input int x0, input int y0, input int x1, input int y1,
                       input logic [23:0] col, input logic [31:0] base,
                       input int bp, input int extra, input bit poke);
        int acc, t, d0, limit;
        bit seen;
        exp_q.delete();
        log_q.delete();
        build(x0, y0, x1, y1, col, base);
        limit = 200 + 8 * (2 + 2 * nb);
        @(posedge clk); #1;
        check("ready_idle", ready, 1);
        check("mask_idle", wdf_mask_din, 16'hFFFF);
        bp_mode = bp;
        stall_done = 0;
        valid = 1;
        x0_s = 10'(x0); y0_s = 10'(y0); x1_s = 10'(x1); y1_s = 10'(y1);
        col_s = col; base_s = base;
        acc = cyc;
        d0 = done_cnt;
        @(posedge clk); #1;
        valid = 0;
        x0_s = 10'($urandom); y0_s = 10'($urandom); x1_s = 10'($urandom); y1_s = 10'($urandom);
        col_s = 24'($urandom); base_s = $urandom;
        check("ready_busy", ready, 0);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            valid = 1;
            col_s = ~col; x0_s = 0; y0_s = 0; x1_s = 10'd1023; y1_s = 10'd1023;
            @(posedge clk); #1;
            valid = 0;
        end
        seen = 0;
        t = 0;
        while (!seen && t < limit) begin
            @(negedge clk);
            t++;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        if (seen && (bp == 0 || bp == 2))
            check("done_cycle", cyc - acc, 2 + 2 * nb + extra);
        check("all_beats_written", exp_q.size(), 0);
        @(negedge clk);
        check("ready_after_done", ready, 1);
        check("one_done", done_cnt - d0, 1);
        bp_mode = 0;
    endtask

    initial begin
        int t, n_af, nz, x0, x1, y0, y1, bp;
        rst_n = 0; valid = 0; af_full = 0; wdf_full = 0;
        x0_s = 0; y0_s = 0; x1_s = 0; y1_s = 0; col_s = 0; base_s = 0;
        #2;
        check("rst_ready", ready, 1);
        check("rst_af", af_wr_en, 0);
        check("rst_wdf", wdf_wr_en, 0);
        check("rst_done", done, 0);
        check("rst_mask", wdf_mask_din, 16'hFFFF);
        check("rst_din", wdf_din, 0);
        check("rst_addr", af_addr_din, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // 5..18 x 10..11: three bursts per row, partial edges.
        run(5, 10, 18, 11, 24'hAABBCC, 32'h0AC0_0000, 0, 0, 0);
        check("rect_beats", log_q.size(), 12);
        if (log_q.size() == 12) begin
            check("rect_bx0_b0_mask", log_q[0].mask, 16'hFFFF);
            check("rect_bx0_b1_mask", log_q[1].mask, 16'h000F);
            check("rect_bx1_b0_mask", log_q[2].mask, 16'h0000);
            check("rect_bx2_b0_mask", log_q[4].mask, 16'hF000);
            check("rect_bx2_b1_mask", log_q[5].mask, 16'hFFFF);
            check("rect_first_addr", log_q[0].addr, 31'h0158_1400);
            check("rect_last_addr", log_q[11].addr, 31'h0158_1608);
            check("rect_din", log_q[0].din, {4{32'h00AABBCC}});
        end

        // Clipped to the bottom-right corner burst.
        run(792, 598, 1000, 700, 24'h010203, 32'h0, 0, 0, 0);
        check("clip_beats", log_q.size(), 4);
        foreach (log_q[i]) check("clip_y_range", log_q[i].addr[18:9] < 10'd600, 1);
        if (log_q.size() == 4) begin
            check("clip_last_y", log_q[3].addr[18:9], 599);
            check("clip_last_bx", log_q[3].addr[8:2], 99);
            check("clip_mask", log_q[0].mask, 16'h0000);
        end

        run(30, 5, 20, 9, 24'h777777, 32'h0, 0, 0, 0);
        check("empty_beats", log_q.size(), 0);

        run(0, 3, 31, 4, 24'h0F0F0F, 32'h0FC0_0000, 2, 3, 0);
        run(100, 0, 163, 2, 24'h5A5A5A, 32'h0, 3, 0, 0);
        run(0, 20, 127, 23, 24'hC0FFEE, 32'h0040_0000, 0, 0, 1);

        // Reset on the 50th beat of a fill.
        exp_q.delete();
        log_q.delete();
        build(0, 0, 1023, 9, 24'h654321, 32'h0);
        @(posedge clk); #1;
        valid = 1; x0_s = 0; y0_s = 0; x1_s = 10'd1023; y1_s = 10'd9; col_s = 24'h654321; base_s = 0;
        @(posedge clk); #1;
        valid = 0;
        t = 0;
        while (log_q.size() < 50 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("beat50_reached", log_q.size(), 50);
        check("strobe_pre_reset", wdf_wr_en, 1);
        rst_n = 0;
        #1;
        check("reset_af_drop", af_wr_en, 0);
        check("reset_wdf_drop", wdf_wr_en, 0);
        check("reset_ready", ready, 1);
        check("reset_mask", wdf_mask_din, 16'hFFFF);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("ready_after_release", ready, 1);

        // Full-width band, 40 rows, after the reset.
        run(0, 0, 1023, 39, 24'h123456, 32'h0, 0, 0, 0);
        n_af = 0;
        nz = 0;
        foreach (log_q[i]) begin
            if (log_q[i].af) n_af++;
            if (log_q[i].mask != 16'h0) nz++;
        end
        check("band_af_count", n_af, 4000);
        check("band_wdf_count", log_q.size(), 8000);
        check("band_masks_zero", nz, 0);
        if (log_q.size() > 0) begin
            check("band_din", log_q[0].din, {4{32'h00123456}});
            check("band_last_y", log_q[log_q.size()-1].addr[18:9], 39);
            check("band_last_bx", log_q[log_q.size()-1].addr[8:2], 99);
        end

        for (int n = 0; n < 40; n++) begin
            x0 = $urandom_range(0, 1023);
            x1 = x0 + $urandom_range(0, 90) - 10;
            if (x1 < 0) x1 = 0;
            if (x1 > 1023) x1 = 1023;
            y0 = $urandom_range(0, 640);
            y1 = y0 + $urandom_range(0, 6) - 1;
            if (y1 < 0) y1 = 0;
            if (y1 > 1023) y1 = 1023;
            bp = $urandom_range(0, 1);
            run(x0, y0, x1, y1, 24'($urandom), $urandom, bp, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
